// File: rtl/stripe_scheduler.sv
// -----------------------------------------------------------------------------
// stripe_scheduler
//
// Purpose:
//   Sequences a striped alignment over a systolic PE array. Each stripe
//   loads one B segment into the array (LOAD_B), streams sequence A into it
//   starting at the stripe's base row (STREAM), then waits for the array to
//   report the stripe result (DRAIN). The best-scoring stripe is tracked
//   across the run. The next stripe's base row is the current base plus the
//   start position reported by the array.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_go                   start pulse (accepted only when idle)
//   i_num_stripes          stripes to run (0 or too large = all stripes)
//   o_a_addr / i_a_data    A memory address / base (1-cycle read latency)
//   o_b_stripe             B segment index for the PE array
//   o_pe_b_load            PE array latches the B segment
//   o_pe_start, o_pe_a     A stream valid and base into the PE array
//   i_stripe_end           PE array finished the current stripe
//   i_start_position       row offset for the next stripe's base
//   i_end_position         row of the best cell within the stripe
//   i_max_score            best score within the stripe
//   o_busy, o_done, o_err  status; o_done is a one-cycle pulse
//   o_stripe_cnt           stripes completed in the current/last run
//   o_best_score/row/stripe best result of the current/last run
//
// Configuration:
//   STRIPE_WATCHDOG_EN     when defined, DRAIN gives up after 4*NUM_PE cycles
//                          without i_stripe_end, sets o_err and finishes.
// -----------------------------------------------------------------------------
module stripe_scheduler #(
   parameter  int NUM_PE  = 64,
   parameter  int SEQ_LEN = 1024,
   parameter  int SCORE_W = 14,
   localparam int POS_W   = $clog2(SEQ_LEN),
   localparam int STR_W   = $clog2(SEQ_LEN / NUM_PE) + 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_go,
   input  logic [STR_W-1:0]   i_num_stripes,
   output logic [POS_W-1:0]   o_a_addr,
   input  logic [1:0]         i_a_data,
   output logic [STR_W-2:0]   o_b_stripe,
   output logic               o_pe_b_load,
   output logic               o_pe_start,
   output logic [1:0]         o_pe_a,
   input  logic               i_stripe_end,
   input  logic [POS_W-1:0]   i_start_position,
   input  logic [POS_W-1:0]   i_end_position,
   input  logic [SCORE_W-1:0] i_max_score,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err,
   output logic [STR_W-1:0]   o_stripe_cnt,
   output logic [SCORE_W-1:0] o_best_score,
   output logic [POS_W:0]     o_best_row,
   output logic [STR_W-2:0]   o_best_stripe
);

   localparam logic [STR_W-1:0] MAX_STR    = STR_W'(SEQ_LEN / NUM_PE);
   localparam logic [POS_W-1:0] LAST_ROW   = POS_W'(SEQ_LEN - 1);
   localparam logic [POS_W:0]   LAST_ROW_X = (POS_W + 1)'(SEQ_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_B,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [STR_W-1:0]   r_num;         // clamped stripe count for this run
   logic [STR_W-2:0]   r_stripe_idx;
   logic [POS_W-1:0]   r_base;        // first A row of the current stripe
   logic [POS_W-1:0]   r_row;         // A row being delivered this STREAM cycle
   logic [POS_W-1:0]   r_a_addr;
   logic               r_pe_b_load;
   logic               r_pe_start;
   logic               r_busy;
   logic               r_done;
   logic [STR_W-1:0]   r_stripe_cnt;
   logic [SCORE_W-1:0] r_best_score;
   logic [POS_W:0]     r_best_row;
   logic [STR_W-2:0]   r_best_stripe;

   logic [STR_W-1:0]   w_num_clamped;
   logic [POS_W:0]     w_base_sum;
   logic [POS_W-1:0]   w_base_next;
   logic [POS_W:0]     w_cand_row;
   logic               w_better;
   logic [STR_W-1:0]   w_cnt_next;
   logic               w_last_stripe;

   assign w_num_clamped = (i_num_stripes == '0 || i_num_stripes > MAX_STR)
                        ? MAX_STR : i_num_stripes;
   // Base advance is computed one bit wider so the saturation test sees overflow.
   assign w_base_sum    = {1'b0, r_base} + {1'b0, i_start_position};
   assign w_base_next   = (w_base_sum > LAST_ROW_X) ? LAST_ROW : w_base_sum[POS_W-1:0];
   assign w_cand_row    = {1'b0, r_base} + {1'b0, i_end_position};
   assign w_better      = i_max_score > r_best_score;   // strict: ties keep the earlier stripe
   assign w_cnt_next    = r_stripe_cnt + 1'b1;
   assign w_last_stripe = (w_cnt_next == r_num);

`ifdef STRIPE_WATCHDOG_EN
   localparam int WD_LIMIT = 4 * NUM_PE;
   localparam int WD_W     = $clog2(WD_LIMIT);
   logic [WD_W-1:0] r_wd;
   logic            r_err;
`endif

   always_ff @(posedge i_clk) begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // below reads the pre-edge values, regardless of statement order.
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_num         <= '0;
         r_stripe_idx  <= '0;
         r_base        <= '0;
         r_row         <= '0;
         r_a_addr      <= '0;
         r_pe_b_load   <= 1'b0;
         r_pe_start    <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_stripe_cnt  <= '0;
         r_best_score  <= '0;
         r_best_row    <= '0;
         r_best_stripe <= '0;
`ifdef STRIPE_WATCHDOG_EN
         r_wd          <= '0;
         r_err         <= 1'b0;
`endif
      end else begin
         // Single-cycle strobes default low; only the entering transition raises them.
         r_done      <= 1'b0;
         r_pe_b_load <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (i_go) begin
                  r_state       <= S_LOAD_B;
                  r_num         <= w_num_clamped;
                  r_stripe_idx  <= '0;
                  r_base        <= '0;
                  r_a_addr      <= '0;
                  r_stripe_cnt  <= '0;
                  r_best_score  <= '0;
                  r_best_row    <= '0;
                  r_best_stripe <= '0;
                  r_busy        <= 1'b1;
                  r_pe_b_load   <= 1'b1;
`ifdef STRIPE_WATCHDOG_EN
                  r_err         <= 1'b0;
`endif
               end
            end

            S_LOAD_B: begin
               // The base row was addressed this cycle; it arrives in the first
               // STREAM cycle while the address runs one row ahead.
               r_state    <= S_STREAM;
               r_pe_start <= 1'b1;
               r_row      <= r_base;
               r_a_addr   <= r_a_addr + 1'b1;
            end

            S_STREAM, S_DRAIN: begin
               if (i_stripe_end) begin
                  if (w_better) begin
                     r_best_score  <= i_max_score;
                     r_best_row    <= w_cand_row;
                     r_best_stripe <= r_stripe_idx;
                  end
                  r_base       <= w_base_next;
                  r_stripe_cnt <= w_cnt_next;
                  r_pe_start   <= 1'b0;
                  if (w_last_stripe) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state      <= S_LOAD_B;
                     r_stripe_idx <= r_stripe_idx + 1'b1;
                     r_a_addr     <= w_base_next;
                     r_pe_b_load  <= 1'b1;
                  end
               end else if (r_state == S_STREAM) begin
                  r_a_addr <= r_a_addr + 1'b1;
                  if (r_row == LAST_ROW) begin
                     r_state    <= S_DRAIN;
                     r_pe_start <= 1'b0;
`ifdef STRIPE_WATCHDOG_EN
                     r_wd       <= '0;
`endif
                  end else begin
                     r_row <= r_row + 1'b1;
                  end
               end else begin
`ifdef STRIPE_WATCHDOG_EN
                  // Give up once the array has been silent for the full budget.
                  if (r_wd == WD_W'(WD_LIMIT - 1)) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_wd <= r_wd + 1'b1;
                  end
`endif
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_a_addr      = r_a_addr;
   assign o_b_stripe    = r_stripe_idx;
   assign o_pe_b_load   = r_pe_b_load;
   assign o_pe_start    = r_pe_start;
   // Memory data is forwarded in the same cycle it arrives; zero outside STREAM.
   assign o_pe_a        = r_pe_start ? i_a_data : 2'b00;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_stripe_cnt  = r_stripe_cnt;
   assign o_best_score  = r_best_score;
   assign o_best_row    = r_best_row;
   assign o_best_stripe = r_best_stripe;

`ifdef STRIPE_WATCHDOG_EN
   assign o_err = r_err;
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_stripe_scheduler.sv
// -----------------------------------------------------------------------------
// tb_stripe_scheduler
//
// Purpose:
//   Directed self-checking bench for stripe_scheduler with default parameters
//   (NUM_PE=64, SEQ_LEN=1024, SCORE_W=14). A bench-side A memory with
//   1-cycle read latency feeds i_a_data. Inputs are driven and outputs
//   sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_stripe_scheduler;

   localparam int NUM_PE  = 64;
   localparam int SEQ_LEN = 1024;
   localparam int SCORE_W = 14;
   localparam int POS_W   = 10;
   localparam int STR_W   = 5;

   logic               clk;
   logic               i_rst;
   logic               i_go;
   logic [STR_W-1:0]   i_num_stripes;
   logic [POS_W-1:0]   o_a_addr;
   logic [1:0]         i_a_data;
   logic [STR_W-2:0]   o_b_stripe;
   logic               o_pe_b_load;
   logic               o_pe_start;
   logic [1:0]         o_pe_a;
   logic               i_stripe_end;
   logic [POS_W-1:0]   i_start_position;
   logic [POS_W-1:0]   i_end_position;
   logic [SCORE_W-1:0] i_max_score;
   logic               o_busy;
   logic               o_done;
   logic               o_err;
   logic [STR_W-1:0]   o_stripe_cnt;
   logic [SCORE_W-1:0] o_best_score;
   logic [POS_W:0]     o_best_row;
   logic [STR_W-2:0]   o_best_stripe;

   logic [1:0] mem [SEQ_LEN];
   int checks = 0;
   int errors = 0;

   stripe_scheduler #(
      .NUM_PE (NUM_PE),
      .SEQ_LEN(SEQ_LEN),
      .SCORE_W(SCORE_W)
   ) dut (
      .i_clk           (clk),
      .i_rst           (i_rst),
      .i_go            (i_go),
      .i_num_stripes   (i_num_stripes),
      .o_a_addr        (o_a_addr),
      .i_a_data        (i_a_data),
      .o_b_stripe      (o_b_stripe),
      .o_pe_b_load     (o_pe_b_load),
      .o_pe_start      (o_pe_start),
      .o_pe_a          (o_pe_a),
      .i_stripe_end    (i_stripe_end),
      .i_start_position(i_start_position),
      .i_end_position  (i_end_position),
      .i_max_score     (i_max_score),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_err           (o_err),
      .o_stripe_cnt    (o_stripe_cnt),
      .o_best_score    (o_best_score),
      .o_best_row      (o_best_row),
      .o_best_stripe   (o_best_stripe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read A memory.
   always @(posedge clk) i_a_data <= mem[o_a_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
         else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
         end
   endtask

   task automatic start_run(input int num);
      i_num_stripes = STR_W'(num);
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
   endtask

   // Entered with the DUT in LOAD_B for stripe idx. Streams the stripe (fully,
   // or only 'early' rows before the array reports) and then pulses
   // i_stripe_end with the given results. If inject is set, a stray i_go and
   // i_stripe_end are driven during LOAD_B and must have no effect.
   task automatic do_stripe(input int base, input int idx, input int early,
                            input int st, input int en, input int sc,
                            input bit inject, input int prev_best);
      check("ld_bload",   32'(o_pe_b_load), 1);
      check("ld_addr",    32'(o_a_addr), base);
      check("ld_bstripe", 32'(o_b_stripe), idx);
      check("ld_pestart", 32'(o_pe_start), 0);
      check("ld_busy",    32'(o_busy), 1);
      if (inject) begin
         i_go = 1'b1;
         i_num_stripes = 5'd1;
         i_stripe_end = 1'b1;
         i_start_position = 10'd500;
         i_end_position = 10'd5;
         i_max_score = 14'd9999;
      end
      tick();
      i_go = 1'b0;
      i_stripe_end = 1'b0;
      check("st_start", 32'(o_pe_start), 1);
      check("st_addr",  32'(o_a_addr), (base + 1) % SEQ_LEN);
      check("st_pea",   32'(o_pe_a), 32'(mem[base]));
      check("st_cnt",   32'(o_stripe_cnt), idx);
      check("st_best",  32'(o_best_score), prev_best);
      if (early > 0) begin
         repeat (early) tick();
         check("early_start", 32'(o_pe_start), 1);
         check("early_pea",   32'(o_pe_a), 32'(mem[base + early]));
      end else begin
         repeat (SEQ_LEN - 1 - base) tick();
         check("last_start", 32'(o_pe_start), 1);
         check("last_pea",   32'(o_pe_a), 32'(mem[SEQ_LEN-1]));
         tick();
         check("drain_start", 32'(o_pe_start), 0);
         check("drain_pea",   32'(o_pe_a), 0);
         check("drain_busy",  32'(o_busy), 1);
         repeat (3) tick();
      end
      i_stripe_end = 1'b1;
      i_start_position = POS_W'(st);
      i_end_position = POS_W'(en);
      i_max_score = SCORE_W'(sc);
      tick();
      i_stripe_end = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},    32'(o_busy), 0);
      check({tag, "_done"},    32'(o_done), 0);
      check({tag, "_err"},     32'(o_err), 0);
      check({tag, "_addr"},    32'(o_a_addr), 0);
      check({tag, "_bstripe"}, 32'(o_b_stripe), 0);
      check({tag, "_bload"},   32'(o_pe_b_load), 0);
      check({tag, "_pestart"}, 32'(o_pe_start), 0);
      check({tag, "_pea"},     32'(o_pe_a), 0);
      check({tag, "_cnt"},     32'(o_stripe_cnt), 0);
      check({tag, "_score"},   32'(o_best_score), 0);
      check({tag, "_row"},     32'(o_best_row), 0);
      check({tag, "_bstr"},    32'(o_best_stripe), 0);
   endtask

   initial begin
      for (int i = 0; i < SEQ_LEN; i++) mem[i] = 2'((i ^ (i >> 3)) & 3);
      i_rst = 1'b1;
      i_go = 1'b0;
      i_num_stripes = '0;
      i_stripe_end = 1'b0;
      i_start_position = '0;
      i_end_position = '0;
      i_max_score = '0;
      repeat (3) tick();
      check_all_zero("rst");
      i_rst = 1'b0;

      // Single stripe: score 300 at row 500, stripe 0.
      start_run(1);
      do_stripe(0, 0, 0, 0, 500, 300, 0, 0);
      check("a_done",   32'(o_done), 1);
      check("a_busy",   32'(o_busy), 1);
      check("a_score",  32'(o_best_score), 300);
      check("a_row",    32'(o_best_row), 500);
      check("a_bstr",   32'(o_best_stripe), 0);
      check("a_cnt",    32'(o_stripe_cnt), 1);
      // i_stripe_end in DONE and then in IDLE is ignored.
      i_stripe_end = 1'b1;
      i_max_score = 14'd9000;
      tick();
      check("a_idle_done", 32'(o_done), 0);
      check("a_idle_busy", 32'(o_busy), 0);
      check("a_hold_score", 32'(o_best_score), 300);
      tick();
      i_stripe_end = 1'b0;
      check("a_idle2_score", 32'(o_best_score), 300);
      check("a_idle2_cnt",   32'(o_stripe_cnt), 1);
      check("a_idle2_busy",  32'(o_busy), 0);

      // Three stripes, starts 100/200/0, scores 50/80/80: tie keeps stripe 1.
      // Stray go and stripe_end during stripe 1's LOAD_B are ignored.
      start_run(3);
      do_stripe(0,   0, 0, 100, 10,   50, 0, 0);
      check("b_cnt1",  32'(o_stripe_cnt), 1);
      check("b_best1", 32'(o_best_score), 50);
      do_stripe(100, 1, 0, 200, 20,   80, 1, 50);
      check("b_cnt2",  32'(o_stripe_cnt), 2);
      check("b_row2",  32'(o_best_row), 120);
      do_stripe(300, 2, 0, 0,   1000, 80, 0, 80);
      check("b_done",  32'(o_done), 1);
      check("b_cnt",   32'(o_stripe_cnt), 3);
      check("b_score", 32'(o_best_score), 80);
      check("b_bstr",  32'(o_best_stripe), 1);
      check("b_row",   32'(o_best_row), 120);
      tick();

      // Early stripe ends; last stripe wins with row 300+1000 = 1300.
      start_run(3);
      do_stripe(0,   0, 5, 100, 3,    10,  0, 0);
      do_stripe(100, 1, 5, 200, 4,    20,  0, 10);
      check("c_row1",  32'(o_best_row), 104);
      do_stripe(300, 2, 0, 0,   1000, 100, 0, 20);
      check("c_done",  32'(o_done), 1);
      check("c_score", 32'(o_best_score), 100);
      check("c_row",   32'(o_best_row), 1300);
      check("c_bstr",  32'(o_best_stripe), 2);
      tick();

      // Stripe count 0 means all 16 stripes; base saturates at 1023.
      start_run(0);
      do_stripe(0,    0, 3, 1000, 5, 1, 0, 0);
      do_stripe(1000, 1, 0, 900,  7, 2, 0, 1);
      check("d_row1", 32'(o_best_row), 1007);
      for (int s = 2; s < 16; s++)
         do_stripe(1023, s, 0, 0, 1023, (s == 15) ? 3 : 2, 0, 2);
      check("d_done",  32'(o_done), 1);
      check("d_cnt",   32'(o_stripe_cnt), 16);
      check("d_row",   32'(o_best_row), 2046);
      check("d_bstr",  32'(o_best_stripe), 15);
      check("d_score", 32'(o_best_score), 3);
      tick();

      // Reset in STREAM of stripe 2, then reset+go together, then fresh start.
      start_run(3);
      do_stripe(0,   0, 2, 100, 0, 5, 0, 0);
      do_stripe(100, 1, 2, 200, 0, 6, 0, 5);
      check("e_ld_addr", 32'(o_a_addr), 300);
      tick();
      tick();
      check("e_stream", 32'(o_pe_start), 1);
      i_rst = 1'b1;
      tick();
      check_all_zero("e_rst");
      i_go = 1'b1;
      i_num_stripes = 5'd1;
      tick();
      check("e_rstgo_busy", 32'(o_busy), 0);
      i_rst = 1'b0;
      i_go = 1'b0;
      tick();
      start_run(1);
      check("e_new_addr",  32'(o_a_addr), 0);
      check("e_new_bstr",  32'(o_b_stripe), 0);
      check("e_new_cnt",   32'(o_stripe_cnt), 0);
      check("e_new_bload", 32'(o_pe_b_load), 1);

      // Stream the stripe and never report its end.
      tick();
      repeat (SEQ_LEN - 1) tick();
      tick();
      check("f_drain", 32'(o_pe_start), 0);
`ifdef STRIPE_WATCHDOG_EN
      repeat (4 * NUM_PE - 1) tick();
      check("f_wd_pre_done", 32'(o_done), 0);
      check("f_wd_pre_err",  32'(o_err), 0);
      tick();
      check("f_wd_done", 32'(o_done), 1);
      check("f_wd_err",  32'(o_err), 1);
      tick();
      check("f_wd_idle", 32'(o_busy), 0);
      check("f_wd_hold", 32'(o_err), 1);
      start_run(1);
      check("f_wd_clr",  32'(o_err), 0);
`else
      repeat (300) tick();
      check("f_hang_busy", 32'(o_busy), 1);
      check("f_hang_done", 32'(o_done), 0);
      check("f_hang_err",  32'(o_err), 0);
`endif
      i_rst = 1'b1;
      tick();
      check("f_rst_busy", 32'(o_busy), 0);
      i_rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
